// File: rtl/seven_seg_scanner.sv
// Scan driver for a 4-digit seven-segment display: rotates the active-low anode
// and holds the value nibbles, loading new ones only at frame boundaries.
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] val_in,
    input  logic [3:0] lower_in,
    input  logic [3:0] upper_in,
    input  logic [3:0] digit_en,
    output logic [3:0] anode,
    output logic [3:0] Val,
    output logic [3:0] lowerY,
    output logic [3:0] upperY,
    output logic       pending,
    output logic       frame_tick
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       digit_q, digit_d;
    logic [3:0]       anode_q, anode_d;
    logic             frame_tick_q, frame_tick_d;
    logic [3:0]       shadow_val_q, shadow_val_d;
    logic [3:0]       shadow_lower_q, shadow_lower_d;
    logic [3:0]       shadow_upper_q, shadow_upper_d;
    logic             pending_q, pending_d;
    logic [3:0]       val_q, val_d;
    logic [3:0]       lower_q, lower_d;
    logic [3:0]       upper_q, upper_d;
    logic             slot_end;
    logic             frame_end;

    // Only one anode may ever be low; any blanking or disabled digit yields all off.
    function automatic logic [3:0] anode_pattern(input logic [1:0] digit,
                                                 input logic       blank,
                                                 input logic [3:0] en);
        logic [3:0] pat;
        pat = 4'b1111;
        if (!blank && en[digit]) begin
            pat = ~(4'b0001 << digit);
        end
        return pat;
    endfunction

    always_comb begin
        slot_end  = (cnt_q == CNT_LAST);
        frame_end = slot_end && (digit_q == 2'd3);

        cnt_d   = cnt_q + CNT_W'(1);
        digit_d = digit_q;
        if (slot_end) begin
            cnt_d   = '0;
            digit_d = digit_q + 2'd1;
        end

        // Registered outputs are derived from next-state so they line up with cnt/digit.
        anode_d      = anode_pattern(digit_d, (cnt_d < CNT_BLANK), digit_en);
        frame_tick_d = (cnt_d == CNT_LAST) && (digit_d == 2'd3);

        val_d     = val_q;
        lower_d   = lower_q;
        upper_d   = upper_q;
        pending_d = pending_q;
        if (frame_end && pending_q) begin
            val_d     = shadow_val_q;
            lower_d   = shadow_lower_q;
            upper_d   = shadow_upper_q;
            pending_d = 1'b0;
        end

        // A load in the commit cycle lands in the shadow after the old shadow committed.
        shadow_val_d   = shadow_val_q;
        shadow_lower_d = shadow_lower_q;
        shadow_upper_d = shadow_upper_q;
        if (load) begin
            shadow_val_d   = val_in;
            shadow_lower_d = lower_in;
            shadow_upper_d = upper_in;
            pending_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q          <= '0;
            digit_q        <= 2'd0;
            anode_q        <= 4'b1111;
            frame_tick_q   <= 1'b0;
            shadow_val_q   <= 4'd0;
            shadow_lower_q <= 4'd0;
            shadow_upper_q <= 4'd0;
            pending_q      <= 1'b0;
            val_q          <= 4'd0;
            lower_q        <= 4'd0;
            upper_q        <= 4'd0;
        end else begin
            cnt_q          <= cnt_d;
            digit_q        <= digit_d;
            anode_q        <= anode_d;
            frame_tick_q   <= frame_tick_d;
            shadow_val_q   <= shadow_val_d;
            shadow_lower_q <= shadow_lower_d;
            shadow_upper_q <= shadow_upper_d;
            pending_q      <= pending_d;
            val_q          <= val_d;
            lower_q        <= lower_d;
            upper_q        <= upper_d;
        end
    end

    assign anode      = anode_q;
    assign Val        = val_q;
    assign lowerY     = lower_q;
    assign upperY     = upper_q;
    assign pending    = pending_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Randomised scoreboard bench for seven_seg_scanner with a frame-position reference model.
module tb_seven_seg_scanner;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] val_in = 4'd0, lower_in = 4'd0, upper_in = 4'd0;
    logic [3:0] digit_en = 4'b1111;
    logic [3:0] anode, Val, lowerY, upperY;
    logic       pending, frame_tick;

    seven_seg_scanner #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .load(load),
        .val_in(val_in), .lower_in(lower_in), .upper_in(upper_in),
        .digit_en(digit_en), .anode(anode), .Val(Val), .lowerY(lowerY),
        .upperY(upperY), .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] anode;
        logic [3:0] val;
        logic [3:0] lower;
        logic [3:0] upper;
        logic       pending;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: position within the 32-cycle frame plus load/commit bookkeeping.
    int         m_pos;
    logic [3:0] m_en;
    logic [3:0] m_sh_v, m_sh_l, m_sh_u;
    logic       m_pend;
    logic [3:0] m_v, m_l, m_u;
    bit         m_known = 0;

    function automatic exp_t model_expect();
        exp_t e;
        int   slot_cnt, slot_digit;
        slot_cnt   = m_pos % DIV;
        slot_digit = m_pos / DIV;
        if (slot_cnt < BLANK || m_en[slot_digit] == 1'b0) e.anode = 4'b1111;
        else e.anode = 4'b1111 ^ (4'(1) << slot_digit);
        e.val     = m_v;
        e.lower   = m_l;
        e.upper   = m_u;
        e.pending = m_pend;
        e.tick    = (m_pos == FRAME - 1);
        return e;
    endfunction

    task automatic model_step(input bit r, input bit ld, input logic [3:0] v,
                              input logic [3:0] l, input logic [3:0] u,
                              input logic [3:0] en);
        if (r) begin
            m_pos = 0; m_en = en; m_pend = 0;
            m_sh_v = 0; m_sh_l = 0; m_sh_u = 0;
            m_v = 0; m_l = 0; m_u = 0;
            m_known = 1;
        end else begin
            if (m_pos == FRAME - 1 && m_pend) begin
                m_v = m_sh_v; m_l = m_sh_l; m_u = m_sh_u; m_pend = 0;
            end
            if (ld) begin
                m_sh_v = v; m_sh_l = l; m_sh_u = u; m_pend = 1;
            end
            m_pos = (m_pos + 1) % FRAME;
            m_en  = en;
        end
    endtask

    task automatic cyc(input bit r, input bit ld, input logic [3:0] v,
                       input logic [3:0] l, input logic [3:0] u,
                       input logic [3:0] en);
        @(posedge clk);
        #1;
        if (m_known) exp_q.push_back(model_expect());
        reset = r; load = ld; val_in = v; lower_in = l; upper_in = u; digit_en = en;
        model_step(r, ld, v, l, u, en);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = '{anode, Val, lowerY, upperY, pending, frame_tick};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL outputs @%0t: got anode=%b val=%h lower=%h upper=%h pend=%b tick=%b, want anode=%b val=%h lower=%h upper=%h pend=%b tick=%b",
                         $time, a.anode, a.val, a.lower, a.upper, a.pending, a.tick,
                         e.anode, e.val, e.lower, e.upper, e.pending, e.tick);
            end
        end
    end

    initial begin
        model_step(1, 0, 0, 0, 0, 4'b1111);

        // Reset held, with a load attempt that must be ignored.
        for (int k = 0; k < 4; k++) cyc(1, (k == 2), 4'hF, 4'hF, 4'hF, 4'b1111);
        for (int k = 0; k < 64; k++)
            cyc(0, (k == 5), 4'hA, 4'h3, 4'h7, 4'b1111);

        // Back-to-back loads, load in the commit cycle, digit-2 disabled in second frame.
        cyc(1, 0, 0, 0, 0, 4'b1111);
        for (int k = 0; k < 96; k++) begin
            logic [3:0] en;
            en = (k >= 31 && k < 63) ? 4'b1011 : 4'b1111;
            case (k)
                10:      cyc(0, 1, 4'h1, 4'h2, 4'h3, en);
                20:      cyc(0, 1, 4'h4, 4'h5, 4'h6, en);
                31:      cyc(0, 1, 4'h9, 4'h9, 4'h9, en);
                default: cyc(0, 0, 4'h0, 4'h0, 4'h0, en);
            endcase
        end

        // Enable toggle mid-slot, then reset while a load is pending.
        cyc(1, 0, 0, 0, 0, 4'b1111);
        for (int k = 0; k < 60; k++) begin
            logic [3:0] en;
            en = (k >= 4) ? 4'b1110 : 4'b1111;
            cyc((k == 20), (k == 5), 4'hC, 4'hD, 4'hE, en);
        end

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            bit         r, ld;
            logic [3:0] en;
            r  = ($urandom_range(0, 299) == 0);
            ld = ($urandom_range(0, 9) == 0);
            en = ($urandom_range(0, 19) == 0) ? 4'($urandom) : digit_en;
            cyc(r, ld, 4'($urandom), 4'($urandom), 4'($urandom), en);
        end

        @(posedge clk);
        #1;
        exp_q.push_back(model_expect());
        repeat (3) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
